// File: rtl/hex_keypad_scanner_if.sv
// Keypad-side and result-side signals of the hex keypad scanner.
// master: the scanner (drives columns and results, reads rows).
// slave:  the keypad/consumer side (drives rows, reads the rest).
interface hex_keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic [7:0] key_byte;

    modport master (
        input  rows,
        output cols,
        output key_code,
        output key_valid,
        output key_down,
        output key_byte
    );

    modport slave (
        output rows,
        input  cols,
        input  key_code,
        input  key_valid,
        input  key_down,
        input  key_byte
    );
endinterface

// File: rtl/hex_keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce.
// One column is driven low per dwell; rows are sampled at the end of each
// dwell, reduced to the lowest pressed code per frame, and debounced over
// whole frames. Each accepted press shifts its code into key_byte.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | no key held, waiting for a frame with a key
// PRESS_CHK   | same key seen in dcnt consecutive frames, not yet accepted
// HELD        | key accepted and still held (any key keeps it held)
// RELEASE_CHK | keypad empty for dcnt consecutive frames, not yet released
module hex_keypad_scanner #(
    parameter int SCAN_DIV        = 200000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hex_keypad_scanner_if.master    kp
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DF_CNT = DW'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    logic [3:0]       rows_meta;
    logic [3:0]       rows_sync;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       col_idx;
    logic [3:0]       cols_q;
    logic             acc_found;
    logic [3:0]       acc_code;
    state_t           state;
    logic [3:0]       cand;
    logic [DW-1:0]    dcnt;
    logic [3:0]       key_code_q;
    logic             key_valid_q;
    logic             key_down_q;
    logic [7:0]       key_byte_q;

    logic             dwell_end;
    logic             frame_tick;
    logic             col_found;
    logic [1:0]       col_row;
    logic [3:0]       col_code;
    logic             frame_found;
    logic [3:0]       frame_code;
    logic [DW-1:0]    dcnt_inc;

    assign dwell_end  = (scan_cnt == CNT_LAST);
    assign frame_tick = dwell_end && (col_idx == 2'd3);
    assign dcnt_inc   = dcnt + 1'b1;

    // Lowest pressed row in the current column; lower rows give lower codes.
    always_comb begin
        col_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!rows_sync[r]) col_row = 2'(r);
        end
    end

    assign col_found = (rows_sync != 4'hF);
    assign col_code  = {col_row, col_idx};

    // Merge this column into the frame result, keeping the lowest code.
    always_comb begin
        frame_found = acc_found;
        frame_code  = acc_code;
        if (col_found && (!acc_found || (col_code < acc_code))) begin
            frame_found = 1'b1;
            frame_code  = col_code;
        end
    end

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
        end else begin
            rows_meta <= kp.rows;
            rows_sync <= rows_meta;
        end
    end

    // Dwell counter and column walk; cols changes only at the dwell wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            col_idx  <= 2'd0;
            cols_q   <= 4'b1110;
        end else if (dwell_end) begin
            scan_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            cols_q   <= {cols_q[2:0], cols_q[3]};
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Frame accumulator: collects the four column samples, cleared at the frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_found <= 1'b0;
            acc_code  <= 4'h0;
        end else if (frame_tick) begin
            acc_found <= 1'b0;
            acc_code  <= 4'h0;
        end else if (dwell_end) begin
            acc_found <= frame_found;
            acc_code  <= frame_code;
        end
    end

    // Debounce FSM, stepped once per frame, with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cand        <= 4'h0;
            dcnt        <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            key_byte_q  <= 8'h00;
        end else begin
            key_valid_q <= 1'b0;
            if (frame_tick) begin
                case (state)
                    IDLE: begin
                        if (frame_found) begin
                            state <= PRESS_CHK;
                            cand  <= frame_code;
                            dcnt  <= DW'(1);
                        end
                    end
                    PRESS_CHK: begin
                        if (frame_found && (frame_code == cand)) begin
                            if (dcnt_inc == DF_CNT) begin
                                state       <= HELD;
                                key_code_q  <= cand;
                                key_byte_q  <= {key_byte_q[3:0], cand};
                                key_valid_q <= 1'b1;
                                key_down_q  <= 1'b1;
                            end else begin
                                dcnt <= dcnt_inc;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    HELD: begin
                        if (!frame_found) begin
                            state <= RELEASE_CHK;
                            dcnt  <= DW'(1);
                        end
                    end
                    RELEASE_CHK: begin
                        if (frame_found) begin
                            state <= HELD;
                        end else if (dcnt_inc == DF_CNT) begin
                            state      <= IDLE;
                            key_down_q <= 1'b0;
                        end else begin
                            dcnt <= dcnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign kp.cols      = cols_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;
    assign kp.key_byte  = key_byte_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: a keypad model answers the column drive,
// key patterns change only at frame boundaries, and a frame-level debounce
// model predicts pulses, codes, the two-digit byte and the held flag.
module tb_hex_keypad_scanner;

    localparam int SD = 4;
    localparam int DF = 3;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = 16'h0000;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses_total = 0;

    // frame-level reference state
    bit       m_held;
    int       m_run;
    int       m_rel;
    int       m_cand;
    bit [3:0] m_code;
    bit [7:0] m_byte;

    hex_keypad_scanner_if kp_if ();

    hex_keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp_if)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column.
    always_comb begin
        kp_if.rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !kp_if.cols[c]) kp_if.rows[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_run = 0; m_rel = 0; m_cand = 0;
        m_code = 4'h0; m_byte = 8'h00;
    endtask

    // Expected pulse count for one frame with the given key set.
    function automatic int model_frame(input logic [15:0] mask);
        bit found;
        int code;
        int pulse;
        found = (mask != 16'h0);
        code  = 0;
        pulse = 0;
        for (int i = 15; i >= 0; i--) if (mask[i]) code = i;
        if (!m_held) begin
            if (m_run > 0) begin
                if (found && code == m_cand) begin
                    m_run++;
                    if (m_run == DF) begin
                        pulse  = 1;
                        m_held = 1;
                        m_run  = 0;
                        m_rel  = 0;
                        m_code = 4'(m_cand);
                        m_byte = {m_byte[3:0], 4'(m_cand)};
                    end
                end else begin
                    m_run = 0;
                end
            end else if (found) begin
                m_cand = code;
                m_run  = 1;
            end
        end else begin
            if (!found) begin
                m_rel++;
                if (m_rel == DF) begin
                    m_held = 0;
                    m_rel  = 0;
                    m_run  = 0;
                end
            end else begin
                m_rel = 0;
            end
        end
        return pulse;
    endfunction

    // Runs one full frame starting right after a frame boundary.
    task automatic run_frame(input logic [15:0] mask, input string tag);
        int p;
        int exp_p;
        logic [3:0] ec;
        p = 0;
        keys = mask;
        for (int k = 1; k <= FRAME; k++) begin
            @(posedge clk);
            #1;
            if (kp_if.key_valid) p++;
            ec = 4'hF;
            ec[(k / SD) % 4] = 1'b0;
            chk({tag, "_cols"}, 32'(kp_if.cols), 32'(ec));
        end
        pulses_total += p;
        exp_p = model_frame(mask);
        chk({tag, "_pulses"}, 32'(p), 32'(exp_p));
        chk({tag, "_code"}, 32'(kp_if.key_code), 32'(m_code));
        chk({tag, "_byte"}, 32'(kp_if.key_byte), 32'(m_byte));
        chk({tag, "_down"}, 32'(kp_if.key_down), 32'(m_held));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        keys  = 16'h0000;
        #2;
        chk({tag, "_rst_cols"}, 32'(kp_if.cols), 32'(4'b1110));
        chk({tag, "_rst_valid"}, 32'(kp_if.key_valid), 32'd0);
        chk({tag, "_rst_down"}, 32'(kp_if.key_down), 32'd0);
        chk({tag, "_rst_code"}, 32'(kp_if.key_code), 32'd0);
        chk({tag, "_rst_byte"}, 32'(kp_if.key_byte), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    localparam logic [15:0] K3  = 16'h0008;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K10 = 16'h0400;
    localparam logic [15:0] K15 = 16'h8000;

    initial begin
        int pstart;
        int kind;
        int hold;
        logic [15:0] mask;

        model_reset();
        repeat (3) @(posedge clk);
        do_reset("init");

        // column walk with no keys
        run_frame(16'h0, "walk");
        run_frame(16'h0, "walk2");

        // clean press of key 6 then release
        pstart = pulses_total;
        for (int f = 0; f < 6; f++) run_frame(K6, "press6");
        chk("press6_one_pulse", 32'(pulses_total - pstart), 32'd1);
        chk("press6_code_k", 32'(kp_if.key_code), 32'h6);
        chk("press6_byte_k", 32'(kp_if.key_byte), 32'h06);
        chk("press6_down_k", 32'(kp_if.key_down), 32'd1);
        for (int f = 0; f < 3; f++) run_frame(16'h0, "rel6");
        chk("rel6_down_k", 32'(kp_if.key_down), 32'd0);

        // reset mid-run with non-zero outputs
        repeat (5) @(posedge clk);
        do_reset("midrun");

        // bounce rejection: two frames only
        pstart = pulses_total;
        run_frame(K6, "bounce");
        run_frame(K6, "bounce");
        for (int f = 0; f < 3; f++) run_frame(16'h0, "bounce_rel");
        chk("bounce_no_pulse", 32'(pulses_total - pstart), 32'd0);
        chk("bounce_byte_k", 32'(kp_if.key_byte), 32'h00);

        // two entries
        do_reset("two");
        pstart = pulses_total;
        for (int f = 0; f < 3; f++) run_frame(K6, "two_a");
        for (int f = 0; f < 3; f++) run_frame(16'h0, "two_arel");
        chk("two_a_pulse", 32'(pulses_total - pstart), 32'd1);
        chk("two_a_byte_k", 32'(kp_if.key_byte), 32'h06);
        for (int f = 0; f < 4; f++) run_frame(K15, "two_b");
        chk("two_b_pulse", 32'(pulses_total - pstart), 32'd2);
        chk("two_b_code_k", 32'(kp_if.key_code), 32'hF);
        chk("two_b_byte_k", 32'(kp_if.key_byte), 32'h6F);
        for (int f = 0; f < 3; f++) run_frame(16'h0, "two_brel");

        // multi-key priority, then change of key while held
        pstart = pulses_total;
        for (int f = 0; f < 4; f++) run_frame(K5 | K10, "multi");
        chk("multi_code_k", 32'(kp_if.key_code), 32'h5);
        for (int f = 0; f < 4; f++) run_frame(K10, "switch");
        chk("multi_one_pulse", 32'(pulses_total - pstart), 32'd1);
        for (int f = 0; f < 3; f++) run_frame(16'h0, "multi_rel");

        // reset while in PRESS_CHK
        do_reset("pc");
        run_frame(K3, "pc_key");
        run_frame(K3, "pc_key");
        keys = K3;
        repeat (5) @(posedge clk);
        do_reset("pc_mid");
        pstart = pulses_total;
        for (int f = 0; f < 4; f++) run_frame(16'h0, "pc_after");
        chk("pc_no_pulse", 32'(pulses_total - pstart), 32'd0);
        chk("pc_byte_k", 32'(kp_if.key_byte), 32'h00);

        // randomized key patterns and hold lengths
        for (int s = 0; s < 60; s++) begin
            kind = $urandom_range(0, 9);
            hold = $urandom_range(1, 5);
            if (kind < 4) mask = 16'h0;
            else if (kind < 8) mask = 16'h1 << $urandom_range(0, 15);
            else mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            for (int f = 0; f < hold; f++) run_frame(mask, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
